// File: rtl/usr_pkg.sv
// Shared types and op encodings for the universal shift register stage.
package usr_pkg;

    localparam int unsigned USR_DATA_W = 4;

    typedef logic [1:0] usr_ctrl_t;

    localparam usr_ctrl_t USR_CLR  = 2'b00;
    localparam usr_ctrl_t USR_SHL  = 2'b01;
    localparam usr_ctrl_t USR_SHR  = 2'b10;
    localparam usr_ctrl_t USR_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        PRESENT
    } seq_state_t;

    typedef struct packed {
        logic [USR_DATA_W-1:0] data;
        usr_ctrl_t             ctrl;
    } usr_cmd_t;

endpackage

// File: rtl/usr_cmd_fifo.sv
// Small synchronous FIFO for USR commands; no full-bypass, occupancy exposed.
module usr_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == CNT_W'(0));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array: written on accepted push only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Queues USR commands, holds each on the USR for a settle time, returns y1.
module usr_cmd_sequencer
    import usr_pkg::*;
#(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    input  logic [1:0]             s_ctrl,
    output logic [DATA_W-1:0]      usr_data_in,
    output logic [1:0]             usr_ctrl,
    input  logic [DATA_W-1:0]      usr_y1,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic [1:0]             m_ctrl,
    output logic [DATA_W-1:0]      m_result,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned CMD_W      = DATA_W + $bits(usr_ctrl_t);
    localparam int unsigned HOLD_CNT_W = $clog2(HOLD_CYC + 1);

    seq_state_t              state;
    seq_state_t              state_nx;
    logic [HOLD_CNT_W-1:0]   hold_cnt;
    logic [HOLD_CNT_W-1:0]   hold_cnt_nx;
    logic [DATA_W-1:0]       usr_data_nx;
    usr_ctrl_t               usr_ctrl_nx;
    logic                    m_valid_nx;
    logic [DATA_W-1:0]       m_data_nx;
    usr_ctrl_t               m_ctrl_nx;
    logic [DATA_W-1:0]       m_result_nx;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [CMD_W-1:0]        fifo_head;

    assign s_ready = !fifo_full;

    usr_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s_valid),
        .wdata ({s_data, s_ctrl}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State, hold counter and all registered outputs; usr_* double as the op registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            usr_data_in <= '0;
            usr_ctrl    <= USR_CLR;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_ctrl      <= USR_CLR;
            m_result    <= '0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_cnt_nx;
            usr_data_in <= usr_data_nx;
            usr_ctrl    <= usr_ctrl_nx;
            m_valid     <= m_valid_nx;
            m_data      <= m_data_nx;
            m_ctrl      <= m_ctrl_nx;
            m_result    <= m_result_nx;
        end
    end

    // Next-state and next-output decode: pop in IDLE, settle in HOLD, handshake in PRESENT.
    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        usr_data_nx = usr_data_in;
        usr_ctrl_nx = usr_ctrl;
        m_valid_nx  = m_valid;
        m_data_nx   = m_data;
        m_ctrl_nx   = m_ctrl;
        m_result_nx = m_result;
        fifo_pop    = 1'b0;

        case (state)
            IDLE: begin
                usr_data_nx = '0;
                usr_ctrl_nx = USR_CLR;
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    usr_data_nx = fifo_head[CMD_W-1 -: DATA_W];
                    usr_ctrl_nx = fifo_head[1:0];
                    hold_cnt_nx = '0;
                    state_nx    = HOLD;
                end
            end
            HOLD: begin
                hold_cnt_nx = hold_cnt + HOLD_CNT_W'(1);
                if (hold_cnt == HOLD_CNT_W'(HOLD_CYC - 1)) begin
                    m_result_nx = usr_y1;
                    m_data_nx   = usr_data_in;
                    m_ctrl_nx   = usr_ctrl;
                    m_valid_nx  = 1'b1;
                    state_nx    = PRESENT;
                end
            end
            PRESENT: begin
                if (m_valid && m_ready) begin
                    m_valid_nx  = 1'b0;
                    usr_data_nx = '0;
                    usr_ctrl_nx = USR_CLR;
                    state_nx    = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: doc/usr_cmd_sequencer.md
Name: usr_cmd_sequencer

Overview:
Clocked upstream stage for the combinational universal shift register (USR). It queues (data, ctrl) commands from a valid/ready source and drives them one at a time onto the USR data_in/ctrl inputs. After a programmable settle time it samples the USR y1 output and returns the result on a valid/ready output channel. This replaces the file-driven stimulus loop with synthesizable sequencing.

Parameters:
DATA_W, 4, width of the USR data path (data_in / y1)
DEPTH, 4, command FIFO depth; power of 2, >= 2
HOLD_CYC, 2, cycles each command is held on the USR before y1 is sampled; >= 1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
s_valid  in  1  command valid
s_ready  out  1  command FIFO can accept
s_data  in  DATA_W  command operand
s_ctrl  in  2  command op (usr_pkg encoding)
usr_data_in  out  DATA_W  to USR data_in
usr_ctrl  out  2  to USR ctrl
usr_y1  in  DATA_W  from USR y1
m_valid  out  1  result valid
m_ready  in  1  result consumer ready
m_data  out  DATA_W  operand that produced the result
m_ctrl  out  2  op that produced the result
m_result  out  DATA_W  sampled usr_y1
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the in-flight command

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, FIFO empty, fifo_count=0, m_valid=0, m_data/m_ctrl/m_result=0, usr_data_in=0, usr_ctrl=2'b00. Queued and in-flight commands are discarded; m_valid drops immediately. Upstream must hold s_valid low during reset.
- s_ready = (fifo_count != DEPTH), combinational from occupancy only. There is no full-bypass: a pop in the same cycle does not free the slot for a push in that cycle.
- Push on s_valid && s_ready. When fifo_count == DEPTH, s_valid is ignored and the data is not written.
- Pointers wrap modulo DEPTH. fifo_count changes by +1, -1, or 0 on a simultaneous push and pop.
- FSM states: IDLE, HOLD, PRESENT.
  - IDLE: usr_data_in=0, usr_ctrl=2'b00. If the FIFO is non-empty, pop the head into the op registers, clear hold_cnt, and go to HOLD.
  - HOLD: usr_data_in/usr_ctrl = op registers, stable for the whole state. hold_cnt increments each cycle. At hold_cnt == HOLD_CYC-1, register m_result<=usr_y1, m_data/m_ctrl<=op, m_valid<=1, and go to PRESENT.
  - PRESENT: usr outputs keep the op registers. m_* are stable while m_valid && !m_ready. On m_valid && m_ready: m_valid<=0 and go to IDLE.
- Latency: a command pushed at edge E0 into an empty, IDLE block is popped at E1. m_valid rises after edge E(1+HOLD_CYC); with the default this is 3 cycles after the push edge.
- Throughput: one command per HOLD_CYC+2 cycles when m_ready is tied high.
- A push arriving during HOLD or PRESENT only queues; it does not disturb the op registers.
- An illegal ctrl value does not exist, since all 4 codes are defined. 2'b00 is passed through, and the USR returns 0.
- Widths: hold_cnt is $clog2(HOLD_CYC+1) bits. There is no arithmetic on data.

Decomposition:
- usr_pkg holds:
  - localparams USR_CLR=2'b00, USR_SHL=2'b01, USR_SHR=2'b10, USR_LOAD=2'b11
  - typedef usr_ctrl_t (logic [1:0])
  - typedef enum seq_state_t {IDLE, HOLD, PRESENT}
  - packed struct usr_cmd_t {data, ctrl}
- Sub-module usr_cmd_fifo is parameterized by DEPTH and the width of usr_cmd_t. It provides push/pop, full/empty, and count, and is reusable for the result side later.

Test Plan:
- Reset, then push data=1011 ctrl=11 with m_ready=1 → m_valid rises 3 cycles after the push edge, m_result=1011, m_data=1011, m_ctrl=11; usr_ctrl=11 during HOLD.
- Push 0111/01, then 1101/10 back-to-back → results in order 1110 then 0110; usr outputs return to 0000/00 in IDLE between them.
- Hold m_ready=0 and push 6 commands on consecutive cycles → 1 in flight plus 4 queued are accepted. s_ready goes low when fifo_count=4, the 6th push is held off, and m_result stays stable until m_ready=1. Then all 5 results drain in order, and the 6th command is accepted once a slot frees.
- Push 1111/00 → m_result=0000.
- Assert rst_n low mid-HOLD with 2 commands queued → m_valid=0, fifo_count=0, usr_ctrl=00 immediately without waiting for a clock edge. After release, no stale result appears and a new command is processed normally.
- Run with HOLD_CYC=1 and DEPTH=2 → latency is 2 cycles and s_ready is low at fifo_count=2.
